// File: rtl/shadow_update_ctrl.sv
// shadow_update_ctrl: arbitrates requesters onto the shadow bank, streams writes, applies and tracks sync/rollback.
// Define SHADOW_UPDATE_CTRL_PRIO_EN for fixed-priority arbitration (requester 0 highest) instead of round-robin.
module shadow_update_ctrl #(
    parameter int NUM_REQ      = 2,
    parameter int NUM_REGS     = 4,
    parameter int REG_WIDTH    = 32,
    parameter int IDX_W        = 3,
    parameter int ACC_WINDOW   = 4,
    parameter int SYNC_TIMEOUT = 256
) (
    input  logic                                cfg_clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]       req_idx,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                  req_last,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  req_done,
    output logic [NUM_REQ-1:0]                  req_err,
    output logic [NUM_REGS-1:0]                 wr_en,
    output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  wr_data,
    output logic                                shadow_apply,
    output logic                                shadow_rollback,
    input  logic                                shadow_busy,
    output logic                                ctrl_busy
);
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int CW = $clog2(SYNC_TIMEOUT + ACC_WINDOW + 1);

    typedef enum logic [2:0] {IDLE, WRITE, APPLY, WAIT_ACC, WAIT_SYNC, ROLLBACK, WAIT_RB, DONE} state_t;

    state_t             state;
    logic [GW-1:0]      g, ptr, pick;
    logic [CW-1:0]      cnt;
    logic               sticky, beat, bad;
    logic [NUM_REQ-1:0] g_oh;
    logic [RW-1:0]      widx;

    // Descending scan so the lowest offset from the start point wins.
    always_comb begin
        pick = '0;
`ifdef SHADOW_UPDATE_CTRL_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[GW'(i)]) pick = GW'(i);
`else
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[GW'((int'(ptr) + i) % NUM_REQ)]) pick = GW'((int'(ptr) + i) % NUM_REQ);
`endif
    end

    assign g_oh      = NUM_REQ'(1) << g;
    assign req_ready = state == WRITE ? g_oh : '0;
    assign beat      = state == WRITE && req_valid[g];
    assign bad       = 32'(req_idx[g]) >= NUM_REGS;
    assign widx      = req_idx[g][RW-1:0];
    assign ctrl_busy = state != IDLE;

    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            g               <= '0;
            ptr             <= '0;
            cnt             <= '0;
            sticky          <= 1'b0;
            req_done        <= '0;
            req_err         <= '0;
            wr_en           <= '0;
            wr_data         <= '0;
            shadow_apply    <= 1'b0;
            shadow_rollback <= 1'b0;
        end else begin
            req_done        <= '0;
            req_err         <= '0;
            wr_en           <= '0;
            shadow_apply    <= 1'b0;
            shadow_rollback <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    g     <= pick;
                    state <= WRITE;
                end
                WRITE: if (beat) begin
                    if (bad) sticky <= 1'b1;
                    else begin
                        wr_en         <= NUM_REGS'(1) << widx;
                        wr_data[widx] <= req_data[g];
                    end
                    if (req_last[g]) begin
                        if (bad || sticky) begin
                            req_done <= g_oh;
                            req_err  <= g_oh;
                            state    <= DONE;
                        end else state <= APPLY;
                    end
                end
                // Entered the cycle after the final wr_en, so apply never overlaps a write.
                APPLY: if (!shadow_busy) begin
                    shadow_apply <= 1'b1;
                    cnt          <= '0;
                    state        <= WAIT_ACC;
                end
                WAIT_ACC: if (shadow_busy) begin
                    cnt   <= '0;
                    state <= WAIT_SYNC;
                end else if (cnt == CW'(ACC_WINDOW)) begin
                    req_done <= g_oh;
                    req_err  <= g_oh;
                    state    <= DONE;
                end else cnt <= cnt + 1'b1;
                WAIT_SYNC: if (!shadow_busy) begin
                    req_done <= g_oh;
                    state    <= DONE;
                end else if (cnt == CW'(SYNC_TIMEOUT - 1)) begin
                    shadow_rollback <= 1'b1;
                    state           <= ROLLBACK;
                end else cnt <= cnt + 1'b1;
                ROLLBACK: state <= WAIT_RB;
                WAIT_RB: if (!shadow_busy) begin
                    req_done <= g_oh;
                    req_err  <= g_oh;
                    state    <= DONE;
                end
                DONE: begin
                    ptr    <= int'(g) == NUM_REQ - 1 ? '0 : g + 1'b1;
                    sticky <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shadow_update_ctrl.sv
// tb_shadow_update_ctrl: directed scenarios against shadow_update_ctrl with a simple bank busy model.
module tb_shadow_update_ctrl;
    logic             cfg_clk, rst_n;
    logic [1:0]       req_valid, req_last, req_ready, req_done, req_err;
    logic [1:0][2:0]  req_idx;
    logic [1:0][31:0] req_data;
    logic [3:0]       wr_en;
    logic [3:0][31:0] wr_data;
    logic             shadow_apply, shadow_rollback, shadow_busy, ctrl_busy;

    shadow_update_ctrl dut (
        .cfg_clk(cfg_clk), .rst_n(rst_n), .req_valid(req_valid), .req_idx(req_idx),
        .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .req_done(req_done),
        .req_err(req_err), .wr_en(wr_en), .wr_data(wr_data), .shadow_apply(shadow_apply),
        .shadow_rollback(shadow_rollback), .shadow_busy(shadow_busy), .ctrl_busy(ctrl_busy)
    );

    typedef struct {int c; logic [3:0] en; logic [3:0][31:0] d;} wr_t;
    typedef struct {int c; logic [1:0] v; logic [1:0] e;} ev_t;

    wr_t        wr_q[$];
    ev_t        dn_q[$], gr_q[$];
    int         ap_q[$], rb_q[$];
    int         cyc = 0, n_cmp = 0, n_fail = 0;
    int         bank_rise = 2, bank_hold = 10, bank_t = -1;
    int         nb[2];
    logic [2:0] bidx[2][4];
    logic [31:0] bdat[2][4];
    logic [1:0] prev_rdy = '0;

    initial begin
        cfg_clk = 0;
        forever #5 cfg_clk = ~cfg_clk;
    end

    always @(posedge cfg_clk) cyc <= cyc + 1;

    // Bank: busy rises bank_rise cycles after apply and stays high bank_hold cycles; rise < 0 means never.
    initial begin
        shadow_busy = 0;
        forever begin
            @(posedge cfg_clk);
            #1;
            if (!rst_n) bank_t = -1;
            else if (shadow_apply) bank_t = 0;
            else if (bank_t >= 0) bank_t++;
            shadow_busy = rst_n && bank_rise >= 0 && bank_t >= bank_rise && bank_t < bank_rise + bank_hold;
        end
    end

    always @(negedge cfg_clk) begin
        if (rst_n) begin
            if (|wr_en) wr_q.push_back('{cyc, wr_en, wr_data});
            if (shadow_apply) ap_q.push_back(cyc);
            if (shadow_rollback) rb_q.push_back(cyc);
            if (|req_done) dn_q.push_back('{cyc, req_done, req_err});
            if (|req_ready && req_ready != prev_rdy) gr_q.push_back('{cyc, req_ready, 2'b00});
        end
        prev_rdy = req_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge cfg_clk);
        #1;
    endtask

    task automatic clr();
        wr_q.delete(); dn_q.delete(); gr_q.delete(); ap_q.delete(); rb_q.delete();
    endtask

    task automatic run(input int ndone);
        int pos[2];
        int t;
        logic [1:0] acc;
        pos = '{0, 0};
        t = 0;
        while (dn_q.size() < ndone && t < 1500) begin
            for (int r = 0; r < 2; r++) begin
                req_valid[r[0]] = pos[r] < nb[r];
                req_last[r[0]]  = pos[r] < nb[r] && pos[r] == nb[r] - 1;
                if (pos[r] < nb[r]) begin
                    req_idx[r[0]]  = bidx[r][pos[r]];
                    req_data[r[0]] = bdat[r][pos[r]];
                end
            end
            acc = req_valid & req_ready;
            tick();
            t++;
            for (int r = 0; r < 2; r++) if (acc[r[0]]) pos[r]++;
        end
        req_valid = '0;
        req_last  = '0;
        n_cmp++;
        if (dn_q.size() < ndone) begin
            n_fail++;
            $display("FAIL run_timeout done_count got %0d need %0d", dn_q.size(), ndone);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = '0; req_last = '0; req_idx = '0; req_data = '0;
        tick(); tick();
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        n_cmp++; if (req_done !== 2'b00) begin n_fail++; $display("FAIL rst_done got %b exp 00", req_done); end
        n_cmp++; if (req_err !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b exp 00", req_err); end
        n_cmp++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL rst_wr_en got %b exp 0000", wr_en); end
        n_cmp++; if (wr_data !== 128'h0) begin n_fail++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
        n_cmp++; if ({shadow_apply, shadow_rollback} !== 2'b00) begin n_fail++; $display("FAIL rst_apply_rb got %b exp 00", {shadow_apply, shadow_rollback}); end
        n_cmp++; if (ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl_busy got %b exp 0", ctrl_busy); end
        rst_n = 1;
        tick(); tick();
        n_cmp++; if (ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ctrl_busy got %b exp 0", ctrl_busy); end
    endtask

    task automatic test_single();
        clr();
        bank_rise = 2; bank_hold = 10;
        nb = '{2, 0};
        bidx[0][0] = 3'd0; bdat[0][0] = 32'hA5A5_0001;
        bidx[0][1] = 3'd2; bdat[0][1] = 32'h0000_00FF;
        run(1);
        n_cmp++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL s1_wr_count got %0d exp 2", wr_q.size()); end
        n_cmp++; if (wr_q[0].en !== 4'b0001) begin n_fail++; $display("FAIL s1_wr0_en got %b exp 0001", wr_q[0].en); end
        n_cmp++; if (wr_q[0].d[0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL s1_wr0_data got %h exp a5a50001", wr_q[0].d[0]); end
        n_cmp++; if (wr_q[1].en !== 4'b0100) begin n_fail++; $display("FAIL s1_wr1_en got %b exp 0100", wr_q[1].en); end
        n_cmp++; if (wr_q[1].d[2] !== 32'h0000_00FF) begin n_fail++; $display("FAIL s1_wr1_data got %h exp 000000ff", wr_q[1].d[2]); end
        n_cmp++; if (wr_q[1].c - wr_q[0].c !== 1) begin n_fail++; $display("FAIL s1_wr_gap got %0d exp 1", wr_q[1].c - wr_q[0].c); end
        n_cmp++; if (gr_q[0].v !== 2'b01 || wr_q[0].c - gr_q[0].c !== 1) begin n_fail++; $display("FAIL s1_grant got %b@%0d exp 01 one cycle before wr", gr_q[0].v, wr_q[0].c - gr_q[0].c); end
        n_cmp++; if (ap_q.size() !== 1 || ap_q[0] - wr_q[1].c !== 1) begin n_fail++; $display("FAIL s1_apply got n=%0d gap=%0d exp n=1 gap=1", ap_q.size(), ap_q[0] - wr_q[1].c); end
        n_cmp++; if (dn_q[0].v !== 2'b01 || dn_q[0].e !== 2'b00) begin n_fail++; $display("FAIL s1_done got %b/%b exp 01/00", dn_q[0].v, dn_q[0].e); end
        n_cmp++; if (dn_q[0].c - ap_q[0] !== 13) begin n_fail++; $display("FAIL s1_done_lat got %0d exp 13", dn_q[0].c - ap_q[0]); end
        n_cmp++; if (rb_q.size() !== 0) begin n_fail++; $display("FAIL s1_rollback got %0d exp 0", rb_q.size()); end
    endtask

    task automatic test_contention(input logic [1:0] first, input logic [1:0] second, input string tag);
        clr();
        bank_rise = 1; bank_hold = 3;
        nb = '{1, 1};
        bidx[0][0] = 3'd1; bdat[0][0] = 32'h1111_0000;
        bidx[1][0] = 3'd3; bdat[1][0] = 32'h2222_0000;
        run(2);
        n_cmp++; if (gr_q[0].v !== first || gr_q[1].v !== second) begin n_fail++; $display("FAIL %s_grant_order got %b,%b exp %b,%b", tag, gr_q[0].v, gr_q[1].v, first, second); end
        n_cmp++; if (dn_q[0].v !== first || dn_q[1].v !== second || (dn_q[0].e | dn_q[1].e) !== 2'b00) begin n_fail++; $display("FAIL %s_done_order got %b,%b err %b exp %b,%b err 00", tag, dn_q[0].v, dn_q[1].v, dn_q[0].e | dn_q[1].e, first, second); end
        n_cmp++; if (gr_q[1].c - dn_q[0].c !== 2) begin n_fail++; $display("FAIL %s_regrant_gap got %0d exp 2", tag, gr_q[1].c - dn_q[0].c); end
        n_cmp++; if (wr_q.size() !== 2 || wr_q[0].en !== (first[0] ? 4'b0010 : 4'b1000) || wr_q[1].en !== (first[0] ? 4'b1000 : 4'b0010)) begin n_fail++; $display("FAIL %s_wr_en got n=%0d %b,%b", tag, wr_q.size(), wr_q[0].en, wr_q[1].en); end
        n_cmp++; if (wr_q[0].d[1] !== 32'h1111_0000 && wr_q[1].d[1] !== 32'h1111_0000) begin n_fail++; $display("FAIL %s_req0_data got %h exp 11110000", tag, wr_q[1].d[1]); end
        n_cmp++; if (wr_q[1].d[3] !== 32'h2222_0000) begin n_fail++; $display("FAIL %s_req1_data got %h exp 22220000", tag, wr_q[1].d[3]); end
    endtask

    task automatic test_bad_index();
        clr();
        nb = '{0, 1};
        bidx[1][0] = 3'd5; bdat[1][0] = 32'hDEAD_BEEF;
        run(1);
        n_cmp++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL bad_wr_en got %0d writes exp 0", wr_q.size()); end
        n_cmp++; if (ap_q.size() !== 0) begin n_fail++; $display("FAIL bad_apply got %0d exp 0", ap_q.size()); end
        n_cmp++; if (dn_q[0].v !== 2'b10 || dn_q[0].e !== 2'b10) begin n_fail++; $display("FAIL bad_done got %b/%b exp 10/10", dn_q[0].v, dn_q[0].e); end
    endtask

    task automatic test_sync_timeout();
        clr();
        bank_rise = 2; bank_hold = 400;
        nb = '{1, 0};
        bidx[0][0] = 3'd1; bdat[0][0] = 32'h0BAD_F00D;
        run(1);
        n_cmp++; if (ap_q.size() !== 1 || rb_q.size() !== 1) begin n_fail++; $display("FAIL to_counts got apply=%0d rb=%0d exp 1,1", ap_q.size(), rb_q.size()); end
        n_cmp++; if (rb_q[0] - ap_q[0] !== 259) begin n_fail++; $display("FAIL to_rb_time got %0d exp 259", rb_q[0] - ap_q[0]); end
        n_cmp++; if (dn_q[0].c - ap_q[0] !== 403) begin n_fail++; $display("FAIL to_done_time got %0d exp 403", dn_q[0].c - ap_q[0]); end
        n_cmp++; if (dn_q[0].v !== 2'b01 || dn_q[0].e !== 2'b01) begin n_fail++; $display("FAIL to_done got %b/%b exp 01/01", dn_q[0].v, dn_q[0].e); end
    endtask

    task automatic test_apply_reject();
        clr();
        bank_rise = -1;
        nb = '{1, 0};
        bidx[0][0] = 3'd3; bdat[0][0] = 32'h1234_5678;
        run(1);
        n_cmp++; if (dn_q[0].c - ap_q[0] !== 5) begin n_fail++; $display("FAIL rej_done_time got %0d exp 5", dn_q[0].c - ap_q[0]); end
        n_cmp++; if (dn_q[0].v !== 2'b01 || dn_q[0].e !== 2'b01) begin n_fail++; $display("FAIL rej_done got %b/%b exp 01/01", dn_q[0].v, dn_q[0].e); end
        n_cmp++; if (rb_q.size() !== 0) begin n_fail++; $display("FAIL rej_rollback got %0d exp 0", rb_q.size()); end
    endtask

    task automatic test_reset_mid_write();
        int t;
        clr();
        req_valid = 2'b10; req_last = 2'b00; req_idx[1] = 3'd0; req_data[1] = 32'h0000_0033;
        t = 0;
        while (!req_ready[1] && t < 10) begin tick(); t++; end
        tick();
        n_cmp++; if (wr_en !== 4'b0001) begin n_fail++; $display("FAIL mid_first_beat got %b exp 0001", wr_en); end
        req_idx[1] = 3'd1; req_data[1] = 32'h0000_0044;
        rst_n = 0;
        #1;
        n_cmp++; if ({req_ready, req_done, req_err, wr_en, shadow_apply, shadow_rollback, ctrl_busy} !== 13'h0) begin n_fail++; $display("FAIL mid_rst_outputs got %b exp all 0", {req_ready, req_done, req_err, wr_en, shadow_apply, shadow_rollback, ctrl_busy}); end
        n_cmp++; if (wr_data !== 128'h0) begin n_fail++; $display("FAIL mid_rst_wr_data got %h exp 0", wr_data); end
        req_valid = '0;
        tick(); tick();
        rst_n = 1;
        repeat (5) tick();
        n_cmp++; if (dn_q.size() !== 0 || rb_q.size() !== 0 || ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL mid_silent got done=%0d rb=%0d busy=%b exp 0,0,0", dn_q.size(), rb_q.size(), ctrl_busy); end
        clr();
        bank_rise = 1; bank_hold = 2;
        nb = '{1, 1};
        bidx[0][0] = 3'd2; bdat[0][0] = 32'h5555_0000;
        bidx[1][0] = 3'd3; bdat[1][0] = 32'h6666_0000;
        run(2);
        n_cmp++; if (gr_q[0].v !== 2'b01) begin n_fail++; $display("FAIL mid_regrant got %b exp 01", gr_q[0].v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention(2'b10, 2'b01, "ctnA");
        test_bad_index();
        test_contention(2'b01, 2'b10, "ctnB");
        test_sync_timeout();
        test_apply_reject();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
